// File: rtl/colour_mem_arbiter.sv
// Round-robin arbiter that shares the fixed-latency colour ROM between two requesters.
// Each response is routed back to the port that issued the access, in issue order.
module colour_mem_arbiter #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 24,
   parameter int unsigned RD_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_data,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_data,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);

   typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

   port_e             last_q;
   logic              grant0;
   logic              grant1;
   logic              grant_any;
   logic [RD_LAT-1:0] tag_vld_q;
   port_e             tag_port_q [RD_LAT];

   // On a tie the port that was not granted most recently wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst) begin
         grant0 = req0_valid & (~req1_valid | (last_q == PORT1));
         grant1 = req1_valid & (~req0_valid | (last_q == PORT0));
      end
   end

   assign grant_any  = grant0 | grant1;
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign mem_en     = grant_any;
   assign mem_addr   = grant0 ? req0_addr : (grant1 ? req1_addr : '0);
   assign busy       = |tag_vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= PORT1;
         tag_vld_q  <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) tag_port_q[i] <= PORT0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
      end else begin
         if (grant_any) last_q <= grant1 ? PORT1 : PORT0;
         tag_vld_q[0]  <= grant_any;
         tag_port_q[0] <= grant1 ? PORT1 : PORT0;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_port_q[i] <= tag_port_q[i-1];
         end
         // The tag leaving the pipe lines up with the ROM data for that access.
         rsp0_valid <= tag_vld_q[RD_LAT-1] && (tag_port_q[RD_LAT-1] == PORT0);
         rsp1_valid <= tag_vld_q[RD_LAT-1] && (tag_port_q[RD_LAT-1] == PORT1);
         if (tag_vld_q[RD_LAT-1] && (tag_port_q[RD_LAT-1] == PORT0)) rsp0_data <= mem_dout;
         if (tag_vld_q[RD_LAT-1] && (tag_port_q[RD_LAT-1] == PORT1)) rsp1_data <= mem_dout;
      end
   end

endmodule

// File: tb/tb_colour_mem_arbiter.sv
// Scoreboard bench for colour_mem_arbiter: directed scenarios followed by
// constrained-random traffic, with a latency ROM model and a reference arbiter.
module tb_colour_mem_arbiter;

   localparam int ADDR_W = 3;
   localparam int DATA_W = 24;
   localparam int RD_LAT = 3;
   localparam int LAT    = RD_LAT + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req1_valid;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic              req0_ready, req1_ready;
   logic              rsp0_valid, rsp1_valid;
   logic [DATA_W-1:0] rsp0_data, rsp1_data;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_dout;
   logic              busy;

   colour_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout), .busy(busy)
   );

   always #5 clk = ~clk;

   // ROM model: the address presented in cycle t appears on mem_dout in cycle t+RD_LAT.
   logic [DATA_W-1:0] rom [8];
   logic [ADDR_W-1:0] ap [RD_LAT];
   initial begin
      rom[0] = 24'h123456; rom[1] = 24'h0000FF; rom[2] = 24'h00FF00; rom[3] = 24'h00FFFF;
      rom[4] = 24'hFF0000; rom[5] = 24'hFF00FF; rom[6] = 24'hFFFF00; rom[7] = 24'hA5C3E1;
      for (int i = 0; i < RD_LAT; i++) ap[i] = '0;
   end
   always @(posedge clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) ap[i] <= ap[i-1];
      ap[0] <= mem_addr;
   end
   assign mem_dout = rom[ap[RD_LAT-1]];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;

   typedef struct {logic [DATA_W-1:0] data; int due;} exp_t;
   exp_t sb [2][$];

   logic              acc0 = 1'b0, acc1 = 1'b0;
   int                model_last = 1;
   int                last_issue = -100;
   logic [DATA_W-1:0] hold_d [2];
   initial begin hold_d[0] = '0; hold_d[1] = '0; end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: responses, busy, grant/issue and reset behaviour, sampled mid-cycle.
   always @(negedge clk) begin
      logic              rv [2];
      logic [DATA_W-1:0] rd [2];
      logic              e0, e1;
      logic [ADDR_W-1:0] ea;
      rv[0] = rsp0_valid; rv[1] = rsp1_valid;
      rd[0] = rsp0_data;  rd[1] = rsp1_data;
      for (int p = 0; p < 2; p++) begin
         if (sb[p].size() > 0 && sb[p][0].due == cyc) begin
            cmp($sformatf("rsp%0d_valid", p), {31'd0, rv[p]}, 32'd1);
            cmp($sformatf("rsp%0d_data", p), {8'd0, rd[p]}, {8'd0, sb[p][0].data});
            hold_d[p] = sb[p][0].data;
            void'(sb[p].pop_front());
         end else begin
            cmp($sformatf("rsp%0d_valid idle", p), {31'd0, rv[p]}, 32'd0);
            cmp($sformatf("rsp%0d_data hold", p), {8'd0, rd[p]}, {8'd0, hold_d[p]});
         end
      end
      cmp("busy", {31'd0, busy}, {31'd0, (cyc - last_issue) >= 1 && (cyc - last_issue) <= RD_LAT});

      if (rst) begin
         cmp("ready in reset", {30'd0, req0_ready, req1_ready}, 32'd0);
         cmp("mem_en in reset", {31'd0, mem_en}, 32'd0);
         sb[0].delete(); sb[1].delete();
         model_last = 1;
         last_issue = -100;
         hold_d[0] = '0; hold_d[1] = '0;
         acc0 = 1'b0; acc1 = 1'b0;
      end else begin
         e0 = req0_valid && (!req1_valid || model_last == 1);
         e1 = req1_valid && !e0;
         ea = e0 ? req0_addr : (e1 ? req1_addr : '0);
         cmp("grant {r0,r1,en}", {29'd0, req0_ready, req1_ready, mem_en}, {29'd0, e0, e1, e0 | e1});
         cmp("mem_addr", {29'd0, mem_addr}, {29'd0, ea});
         if (e0) begin sb[0].push_back('{rom[req0_addr], cyc + LAT}); model_last = 0; last_issue = cyc; end
         if (e1) begin sb[1].push_back('{rom[req1_addr], cyc + LAT}); model_last = 1; last_issue = cyc; end
         acc0 = req0_valid & req0_ready;
         acc1 = req1_valid & req1_ready;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic v0, input logic [ADDR_W-1:0] a0,
                        input logic v1, input logic [ADDR_W-1:0] a1);
      req0_valid = v0; req0_addr = a0; req1_valid = v1; req1_addr = a1;
   endtask

   task automatic idle(input int n);
      drive(0, '0, 0, '0);
      repeat (n) tick();
   endtask

   initial begin
      // Reset with both requests asserted: nothing may be granted.
      rst = 1'b1;
      drive(1, 3'd2, 1, 3'd3);
      repeat (3) tick();
      rst = 1'b0;
      idle(2);

      // Single request from port 0, response four cycles later.
      drive(1, 3'd1, 0, '0);
      #2;
      cmp("t2 req0_ready", {31'd0, req0_ready}, 32'd1);
      cmp("t2 mem_addr", {29'd0, mem_addr}, 32'd1);
      tick();
      idle(6);

      // Fresh pointer, both ports streaming: grants alternate starting at port 0.
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 3'd2, 1, 3'd3);
         #2;
         cmp("t3 alternate", {30'd0, req0_ready, req1_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
         tick();
      end
      idle(6);

      // Burst on port 1.
      for (int i = 4; i <= 6; i++) begin
         drive(0, '0, 1, 3'(i));
         tick();
      end
      idle(6);

      // Reset two cycles after issue discards the access.
      drive(1, 3'd1, 0, '0);
      tick();
      idle(1);
      rst = 1'b1; tick(); rst = 1'b0;
      #2;
      cmp("t5 busy after reset", {31'd0, busy}, 32'd0);
      idle(6);

      // Pointer holds across idle cycles: port 1 wins the following tie.
      drive(1, 3'd7, 0, '0);
      tick();
      idle(2);
      drive(1, 3'd1, 1, 3'd0);
      #2;
      cmp("t6 req1 first", {30'd0, req0_ready, req1_ready}, 32'd1);
      tick();
      drive(1, 3'd1, 0, '0);
      tick();
      idle(6);

      // Random traffic obeying the hold-until-ready protocol, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 99) < 60);
            req0_addr  = 3'($urandom);
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 99) < 60);
            req1_addr  = 3'($urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      idle(10);

      cmp("scoreboard drained", sb[0].size() + sb[1].size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
